// File: rtl/ticket_vendor_multi.sv
// Multi-destination ticket vendor: coin credit, price table, ticket and change handshakes.
// Ports: clk/reset_n; coin_valid/value -> coin_ack/reject pulses; sel_valid/dest/qty -> sel_error;
//        cancel; cfg_we/addr/price; ticket_valid/ready/dest; change_valid/ready/amount;
//        credit, state, tickets_sold status.
module ticket_vendor_multi #(
   parameter int NUM_DEST   = 4,
   parameter int DEST_W     = 2,
   parameter int CREDIT_W   = 10,
   parameter int COIN_W     = 4,
   parameter int MAX_QTY    = 3,
   parameter int PRICE_STEP = 50,
   parameter int TIMEOUT    = 1000
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                coin_valid,
   input  logic [COIN_W-1:0]   coin_value,
   output logic                coin_ack,
   output logic                coin_reject,
   input  logic                sel_valid,
   input  logic [DEST_W-1:0]   sel_dest,
   input  logic [1:0]          sel_qty,
   output logic                sel_error,
   input  logic                cancel,
   input  logic                cfg_we,
   input  logic [DEST_W-1:0]   cfg_addr,
   input  logic [CREDIT_W-1:0] cfg_price,
   output logic                ticket_valid,
   input  logic                ticket_ready,
   output logic [DEST_W-1:0]   ticket_dest,
   output logic                change_valid,
   input  logic                change_ready,
   output logic [CREDIT_W-1:0] change_amount,
   output logic [CREDIT_W-1:0] credit,
   output logic [1:0]          state,
   output logic [15:0]         tickets_sold
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COLLECT  = 2'd1,
      DISPENSE = 2'd2,
      CHANGE   = 2'd3
   } state_t;

   localparam int TMR_W  = $clog2(TIMEOUT + 1);
   localparam int COST_W = CREDIT_W + 2;

   state_t              cur, nxt;
   logic [CREDIT_W-1:0] price [NUM_DEST];
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic                sel_set_q, sel_set_d;
   logic [DEST_W-1:0]   dest_q, dest_d;
   logic [1:0]          qty_q, qty_d;
   logic [1:0]          rem_q, rem_d;
   logic [15:0]         sold_q, sold_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic                ack_q, rej_q, err_q;
   logic                ack_d, rej_d, err_d;

   logic                open;
   logic [CREDIT_W:0]   sum;
   logic [CREDIT_W:0]   base;
   logic [COST_W-1:0]   cost;
   logic [COST_W-1:0]   left;
   logic                coin_fit, coin_ok;
   logic                in_range, sel_ok;
   logic                timeout_hit, abort, buy;

   assign open     = (cur == IDLE) || (cur == COLLECT);
   assign sum      = {1'b0, credit_q}
                   + {{(CREDIT_W + 1 - COIN_W){1'b0}}, coin_value};
   assign coin_fit = coin_valid && open && (sum <= {1'b0, {CREDIT_W{1'b1}}});
   assign in_range = ({{(32 - DEST_W){1'b0}}, sel_dest} < NUM_DEST)
                   && (sel_qty != 2'd0)
                   && ({30'd0, sel_qty} <= MAX_QTY);
   assign sel_ok   = sel_valid && open && in_range;

   // Inactivity only counts when neither a coin nor a selection shows up.
   assign timeout_hit = (cur == COLLECT) && (timer_q >= TMR_W'(TIMEOUT))
                      && !coin_fit && !sel_ok;
   assign abort   = (cur == COLLECT) && (cancel || timeout_hit);
   assign coin_ok = coin_fit && !abort;

   assign cost = COST_W'(price[dest_q]) * COST_W'(qty_q);
   assign buy  = (cur == COLLECT) && sel_set_q && !abort
               && ({2'b00, credit_q} >= cost);

   // A coin arriving on the purchase cycle is folded into the remaining credit.
   assign base = coin_ok ? sum : {1'b0, credit_q};
   assign left = {1'b0, base} - cost;

   always_comb begin
      nxt       = cur;
      credit_d  = credit_q;
      sel_set_d = sel_set_q;
      dest_d    = dest_q;
      qty_d     = qty_q;
      rem_d     = rem_q;
      sold_d    = sold_q;
      timer_d   = timer_q;
      ack_d     = coin_ok;
      rej_d     = coin_valid && !coin_ok;
      err_d     = sel_valid && open && !in_range;
      unique case (cur)
         IDLE: begin
            if (coin_ok) credit_d = sum[CREDIT_W-1:0];
            if (sel_ok) begin
               sel_set_d = 1'b1;
               dest_d    = sel_dest;
               qty_d     = sel_qty;
            end
            if (coin_ok || sel_ok) begin
               nxt     = COLLECT;
               timer_d = '0;
            end
         end
         COLLECT: begin
            if (abort) begin
               sel_set_d = 1'b0;
               timer_d   = '0;
               nxt       = (credit_q != '0) ? CHANGE : IDLE;
            end else if (buy) begin
               credit_d  = left[CREDIT_W-1:0];
               sel_set_d = 1'b0;
               rem_d     = qty_q;
               timer_d   = '0;
               nxt       = DISPENSE;
            end else begin
               if (coin_ok) credit_d = sum[CREDIT_W-1:0];
               if (sel_ok) begin
                  sel_set_d = 1'b1;
                  dest_d    = sel_dest;
                  qty_d     = sel_qty;
               end
               if (coin_ok || sel_ok)
                  timer_d = '0;
               else if (timer_q < TMR_W'(TIMEOUT))
                  timer_d = timer_q + TMR_W'(1);
            end
         end
         DISPENSE: begin
            if (ticket_ready) begin
               rem_d  = rem_q - 2'd1;
               sold_d = sold_q + 16'd1;
               if (rem_q == 2'd1)
                  nxt = (credit_q != '0) ? CHANGE : IDLE;
            end
         end
         CHANGE: begin
            if (change_ready) begin
               credit_d  = '0;
               sel_set_d = 1'b0;
               nxt       = IDLE;
            end
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur       <= IDLE;
         credit_q  <= '0;
         sel_set_q <= 1'b0;
         dest_q    <= '0;
         qty_q     <= '0;
         rem_q     <= '0;
         sold_q    <= '0;
         timer_q   <= '0;
         ack_q     <= 1'b0;
         rej_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         cur       <= nxt;
         credit_q  <= credit_d;
         sel_set_q <= sel_set_d;
         dest_q    <= dest_d;
         qty_q     <= qty_d;
         rem_q     <= rem_d;
         sold_q    <= sold_d;
         timer_q   <= timer_d;
         ack_q     <= ack_d;
         rej_q     <= rej_d;
         err_q     <= err_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_DEST; i++)
            price[i] <= CREDIT_W'(PRICE_STEP * (i + 1));
      end else if (cfg_we && ({{(32 - DEST_W){1'b0}}, cfg_addr} < NUM_DEST)) begin
         price[cfg_addr] <= cfg_price;
      end
   end

   assign coin_ack      = ack_q;
   assign coin_reject   = rej_q;
   assign sel_error     = err_q;
   assign ticket_valid  = (cur == DISPENSE);
   assign ticket_dest   = dest_q;
   assign change_valid  = (cur == CHANGE);
   assign change_amount = (cur == CHANGE) ? credit_q : '0;
   assign credit        = credit_q;
   assign state         = cur;
   assign tickets_sold  = sold_q;

endmodule

// File: tb/tb_ticket_vendor_multi.sv
// Self-checking bench for ticket_vendor_multi.
// Scoreboard queues hold expected ticket destinations and change amounts.
module tb_ticket_vendor_multi;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       coin_valid;
   logic [3:0] coin_value;
   logic       coin_ack, coin_reject;
   logic       sel_valid;
   logic [1:0] sel_dest, sel_qty;
   logic       sel_error;
   logic       cancel;
   logic       cfg_we;
   logic [1:0] cfg_addr;
   logic [9:0] cfg_price;
   logic       ticket_valid, ticket_ready;
   logic [1:0] ticket_dest;
   logic       change_valid, change_ready;
   logic [9:0] change_amount, credit;
   logic [1:0] state;
   logic [15:0] tickets_sold;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_tkt [$];
   int exp_chg [$];

   always #5 clk = ~clk;

   ticket_vendor_multi dut (
      .clk(clk), .reset_n(reset_n),
      .coin_valid(coin_valid), .coin_value(coin_value),
      .coin_ack(coin_ack), .coin_reject(coin_reject),
      .sel_valid(sel_valid), .sel_dest(sel_dest), .sel_qty(sel_qty),
      .sel_error(sel_error), .cancel(cancel),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_price(cfg_price),
      .ticket_valid(ticket_valid), .ticket_ready(ticket_ready),
      .ticket_dest(ticket_dest),
      .change_valid(change_valid), .change_ready(change_ready),
      .change_amount(change_amount), .credit(credit),
      .state(state), .tickets_sold(tickets_sold)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Handshakes complete at the next rising edge; sample mid-cycle.
   always @(negedge clk) begin
      if (reset_n) begin
         if (ticket_valid && change_valid)
            check("excl_valid", 32'd1, 32'd0);
         if (ticket_valid && ticket_ready) begin
            if (exp_tkt.size() == 0) check("tkt_extra", 32'd1, 32'd0);
            else check("tkt_dest", 32'(ticket_dest), 32'(exp_tkt.pop_front()));
         end
         if (change_valid && change_ready) begin
            if (exp_chg.size() == 0) check("chg_extra", 32'd1, 32'd0);
            else check("chg_amt", 32'(change_amount), 32'(exp_chg.pop_front()));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic coin(input int v);
      coin_valid = 1'b1;
      coin_value = 4'(v);
      tick();
      coin_valid = 1'b0;
   endtask

   task automatic sel(input int d, input int q);
      sel_valid = 1'b1;
      sel_dest  = 2'(d);
      sel_qty   = 2'(q);
      tick();
      sel_valid = 1'b0;
   endtask

   task automatic cfg(input int a, input int p);
      cfg_we    = 1'b1;
      cfg_addr  = 2'(a);
      cfg_price = 10'(p);
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic wait_state(input string tag, input int s, input int budget);
      for (int i = 0; i < budget && 32'(state) != s; i++) tick();
      check(tag, 32'(state), 32'(s));
   endtask

   initial begin
      reset_n = 1'b0;
      coin_valid = 0; coin_value = 0;
      sel_valid = 0; sel_dest = 0; sel_qty = 0;
      cancel = 0; cfg_we = 0; cfg_addr = 0; cfg_price = 0;
      ticket_ready = 1; change_ready = 1;
      tick(); tick();
      check("rst_state", 32'(state), 32'd0);
      check("rst_credit", 32'(credit), 32'd0);
      check("rst_sold", 32'(tickets_sold), 32'd0);
      check("rst_tv", 32'(ticket_valid), 32'd0);
      check("rst_cv", 32'(change_valid), 32'd0);
      check("rst_ack", 32'(coin_ack), 32'd0);
      reset_n = 1'b1;
      tick();

      // Exact payment: no change, straight back to IDLE
      coin(10);
      check("s1_ack", 32'(coin_ack), 32'd1);
      check("s1_collect", 32'(state), 32'd1);
      coin(10); coin(10);
      exp_tkt.push_back(0);
      sel(0, 1);
      check("s1_hold", 32'(state), 32'd1);
      coin(10); coin(10);
      check("s1_credit50", 32'(credit), 32'd50);
      wait_state("s1_idle", 0, 10);
      check("s1_credit0", 32'(credit), 32'd0);
      check("s1_sold", 32'(tickets_sold), 32'd1);

      // Two tickets with a stalled taker, change 15
      ticket_ready = 0;
      coin(15);
      exp_tkt.push_back(3); exp_tkt.push_back(3);
      exp_chg.push_back(15);
      sel(3, 2);
      for (int i = 0; i < 40; i++) coin(10);
      wait_state("s2_disp", 2, 5);
      tick(); tick();
      check("s2_tv", 32'(ticket_valid), 32'd1);
      check("s2_dest", 32'(ticket_dest), 32'd3);
      check("s2_cv", 32'(change_valid), 32'd0);
      check("s2_credit", 32'(credit), 32'd15);
      ticket_ready = 1;
      wait_state("s2_change", 3, 10);
      check("s2_amt", 32'(change_amount), 32'd15);
      wait_state("s2_idle", 0, 10);
      check("s2_sold", 32'(tickets_sold), 32'd3);

      // Credit saturation: reject without wrap
      for (int i = 0; i < 68; i++) coin(15);
      check("s3_credit", 32'(credit), 32'd1020);
      coin(8);
      check("s3_rej", 32'(coin_reject), 32'd1);
      check("s3_noack", 32'(coin_ack), 32'd0);
      check("s3_keep", 32'(credit), 32'd1020);
      exp_chg.push_back(1020);
      cancel = 1; tick(); cancel = 0;
      wait_state("s3_idle", 0, 10);

      // Cancel beats a same-cycle coin
      coin(5);
      exp_chg.push_back(5);
      cancel = 1; coin_valid = 1; coin_value = 5;
      tick();
      cancel = 0; coin_valid = 0;
      check("s4_rej", 32'(coin_reject), 32'd1);
      check("s4_change", 32'(state), 32'd3);
      check("s4_credit", 32'(credit), 32'd5);
      wait_state("s4_idle", 0, 10);

      // Invalid selection
      sel(1, 0);
      check("sel_err", 32'(sel_error), 32'd1);
      check("sel_err_idle", 32'(state), 32'd0);

      // Inactivity timeout refunds
      coin(7);
      exp_chg.push_back(7);
      for (int i = 0; i < 990; i++) tick();
      check("s5_wait", 32'(state), 32'd1);
      wait_state("s5_change", 3, 50);
      wait_state("s5_idle", 0, 10);

      // Reprogrammed price, three tickets
      cfg(1, 20);
      for (int i = 0; i < 4; i++) coin(15);
      exp_tkt.push_back(1); exp_tkt.push_back(1); exp_tkt.push_back(1);
      sel(1, 3);
      wait_state("s6_idle", 0, 20);
      check("s6_credit", 32'(credit), 32'd0);
      check("s6_sold", 32'(tickets_sold), 32'd6);

      // Reset mid-DISPENSE discards the ticket and restores prices
      ticket_ready = 0;
      coin(15); coin(5);
      sel(1, 1);
      wait_state("s6_disp", 2, 5);
      reset_n = 0;
      #1;
      check("s6_rst_state", 32'(state), 32'd0);
      check("s6_rst_tv", 32'(ticket_valid), 32'd0);
      check("s6_rst_sold", 32'(tickets_sold), 32'd0);
      tick();
      reset_n = 1;
      ticket_ready = 1;
      tick();
      for (int i = 0; i < 4; i++) coin(15);
      sel(1, 1);
      tick(); tick(); tick();
      check("s6_price100", 32'(state), 32'd1);
      exp_tkt.push_back(1);
      for (int i = 0; i < 4; i++) coin(10);
      wait_state("s6b_idle", 0, 10);
      check("s6b_sold", 32'(tickets_sold), 32'd1);

      // Zero price dispenses with zero credit
      cfg(2, 0);
      exp_tkt.push_back(2);
      sel(2, 1);
      wait_state("free_idle", 0, 10);
      check("free_sold", 32'(tickets_sold), 32'd2);
      check("free_credit", 32'(credit), 32'd0);

      tick();
      check("tkt_q_empty", 32'(exp_tkt.size()), 32'd0);
      check("chg_q_empty", 32'(exp_chg.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
